// File: rtl/harvard_mem_pkg.sv
// Shared widths, defaults and address-window helper for the Harvard data memory.
// Optional range checking is enabled by defining DMEM_RANGE_CHECK_EN.
package harvard_mem_pkg;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;
  localparam logic [ADDR_W-1:0] DMEM_BASE_DEFAULT = 32'h0000_0000;

  // Window size in bytes, one bit wider than an address so a window ending at 2^32 still fits.
  function automatic logic [ADDR_W:0] windowBytes(input int unsigned depth);
    return (ADDR_W+1)'(depth) << 2;
  endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Turns a CPU byte address into a word index relative to BASE_ADDR, plus window and alignment flags.
// The index always wraps modulo the memory size; the flags are only consumed when DMEM_RANGE_CHECK_EN is defined.
module dmem_addr_decode
  import harvard_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DMEM_BASE_DEFAULT
) (
  input  logic [ADDR_W-1:0]              addr_i,
  output logic [$clog2(DEPTH_WORDS)-1:0] index_o,
  output logic                           in_range_o,
  output logic                           aligned_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [ADDR_W-1:0] offset;

  assign offset    = addr_i - BASE_ADDR;
  assign index_o   = offset[IDX_W+1:2];
  assign aligned_o = (addr_i[1:0] == 2'b00);

  // Checking against BASE_ADDR separately catches addresses below the window whose offset wrapped around.
  assign in_range_o = (addr_i >= BASE_ADDR) && ({1'b0, offset} < windowBytes(DEPTH_WORDS));

endmodule

// File: rtl/harvard_data_memory.sv
// Word-addressed data memory for mips_cpu_harvard: combinational read, clocked write, async clear on reset.
// Define DMEM_RANGE_CHECK_EN to reject out-of-window or misaligned accesses and report them in simulation.
module harvard_data_memory
  import harvard_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DMEM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              clk_enable,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_writedata,
  input  logic              data_write,
  input  logic              data_read,
  input  logic              reset,
  output logic [DATA_W-1:0] data_readdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]  wordIndex;
  logic              inRange;
  logic              isAligned;
  logic              accessOk;
  logic              writeEn;

  dmem_addr_decode #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_decode (
    .addr_i     (data_address),
    .index_o    (wordIndex),
    .in_range_o (inRange),
    .aligned_o  (isAligned)
  );

`ifdef DMEM_RANGE_CHECK_EN
  assign accessOk = inRange && isAligned;

  always_ff @(posedge clk) begin
    if (!reset && (data_read || data_write) && !accessOk)
      $error("harvard_data_memory: illegal access at address 0x%08h", data_address);
  end
`else
  logic unusedFlags;
  assign unusedFlags = inRange ^ isAligned;
  assign accessOk    = 1'b1;
`endif

  // An X strobe makes the if-condition unknown, which simulation treats as no write.
  assign writeEn = clk_enable && data_write && accessOk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++)
        mem_q[i] <= '0;
    end else if (writeEn) begin
      mem_q[wordIndex] <= data_writedata;
    end
  end

  // Read path ignores clk_enable so a stalled CPU still sees its operand.
  always_comb begin
    data_readdata = '0;
    if (data_read && !reset && accessOk)
      data_readdata = mem_q[wordIndex];
  end

endmodule

// File: tb/tb_harvard_data_memory.sv
// Directed bench for harvard_data_memory: a vector table of single-cycle accesses plus reset sequences.
// Expected values for out-of-window vectors change when DMEM_RANGE_CHECK_EN is defined.
module tb_harvard_data_memory;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic        en;
    logic [31:0] expPre;
    logic [31:0] expPost;
  } vec_t;

  logic        clk = 1'b0;
  logic        clk_enable;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic        data_write;
  logic        data_read;
  logic        reset;
  logic [31:0] data_readdata;

  int compared = 0;
  int mismatched = 0;

  vec_t vecs[14];

  harvard_data_memory #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .clk_enable     (clk_enable),
    .data_address   (data_address),
    .data_writedata (data_writedata),
    .data_write     (data_write),
    .data_read      (data_read),
    .reset          (reset),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] expected);
    compared++;
    if (data_readdata !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, data_readdata, expected);
    end
  endtask

  // Drives one vector after a falling edge, checks before and after the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    data_address   = v.addr;
    data_writedata = v.wdata;
    data_write     = v.wr;
    data_read      = v.rd;
    clk_enable     = v.en;
    #1;
    checkOutput({v.name, "/pre"}, v.expPre);
    @(posedge clk);
    #1;
    checkOutput({v.name, "/post"}, v.expPost);
    data_write = 1'b0;
  endtask

  task automatic setVec(input int i, input string name, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic wr, input logic rd,
                        input logic en, input logic [31:0] expPre, input logic [31:0] expPost);
    vecs[i].name    = name;
    vecs[i].addr    = addr;
    vecs[i].wdata   = wdata;
    vecs[i].wr      = wr;
    vecs[i].rd      = rd;
    vecs[i].en      = en;
    vecs[i].expPre  = expPre;
    vecs[i].expPost = expPost;
  endtask

  initial begin
    logic [31:0] wrapOld;
    logic [31:0] wrapNew;
    logic [31:0] wrapRead;
    logic [31:0] misRead;

`ifdef DMEM_RANGE_CHECK_EN
    wrapOld  = 32'h0;
    wrapNew  = 32'h0;
    wrapRead = 32'h0;
    misRead  = 32'h0;
`else
    wrapOld  = 32'h0;
    wrapNew  = 32'h11;
    wrapRead = 32'h11;
    misRead  = 32'hDEAD_BEEF;
`endif

    //      name          addr          wdata          wr    rd    en    expPre         expPost
    setVec(0,  "wrDeadbeef", 32'h10,       32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0);
    setVec(1,  "rdDeadbeef", 32'h10,       32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF,  32'hDEADBEEF);
    setVec(2,  "rdOff",      32'h10,       32'h0,        1'b0, 1'b0, 1'b1, 32'h0,         32'h0);
    setVec(3,  "wrFrozen",   32'h20,       32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
    setVec(4,  "rdFrozen",   32'h20,       32'h0,        1'b0, 1'b1, 1'b1, 32'h0,         32'h0);
    setVec(5,  "rdWrSame",   32'h30,       32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'h0,         32'hA5A5A5A5);
    setVec(6,  "rdStalled",  32'h30,       32'h0,        1'b0, 1'b1, 1'b0, 32'hA5A5A5A5,  32'hA5A5A5A5);
    setVec(7,  "wrWrap",     32'h1000,     32'h11,       1'b1, 1'b1, 1'b1, wrapOld,       wrapNew);
    setVec(8,  "rdWrapZero", 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, wrapRead,      wrapRead);
    setVec(9,  "rdMisalign", 32'h13,       32'h0,        1'b0, 1'b1, 1'b1, misRead,       misRead);
    setVec(10, "rdTopWord",  32'hFFC,      32'h0,        1'b0, 1'b1, 1'b1, 32'h0,         32'h0);
    setVec(11, "wrTopWord",  32'hFFC,      32'h0BADF00D, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0BADF00D);
    setVec(12, "wrOverDead", 32'h10,       32'h55,       1'b1, 1'b1, 1'b1, 32'hDEADBEEF,  32'h55);
    setVec(13, "rdNeighbor", 32'h14,       32'h0,        1'b0, 1'b1, 1'b1, 32'h0,         32'h0);

    clk_enable     = 1'b1;
    data_address   = 32'h0;
    data_writedata = 32'h0;
    data_write     = 1'b0;
    data_read      = 1'b1;
    reset          = 1'b1;
    #2;
    checkOutput("resetRead", 32'h0);

    // Write set up while still in reset must land on the first rising edge after release.
    @(negedge clk);
    data_address   = 32'h8;
    data_writedata = 32'h0000_0077;
    data_write     = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("firstWrite/pre", 32'h0);
    @(posedge clk);
    #1;
    checkOutput("firstWrite/post", 32'h0000_0077);
    data_write = 1'b0;

    $display("[TB] applying %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++)
      applyStimulus(vecs[i]);

    // Reset pulse in the middle of a write cycle: the write is lost and everything reads zero.
    @(negedge clk);
    data_address   = 32'h10;
    data_writedata = 32'h1234_5678;
    data_write     = 1'b1;
    data_read      = 1'b1;
    clk_enable     = 1'b1;
    #1;
    checkOutput("midWrite/beforeReset", 32'h55);
    reset = 1'b1;
    #1;
    checkOutput("midWrite/inReset", 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midWrite/edgeInReset", 32'h0);
    @(negedge clk);
    data_write = 1'b0;
    reset      = 1'b0;
    #1;
    checkOutput("midWrite/lost", 32'h0);
    data_address = 32'h30;
    #1;
    checkOutput("clearedA5", 32'h0);
    data_address = 32'h8;
    #1;
    checkOutput("cleared77", 32'h0);
    data_address = 32'hFFC;
    #1;
    checkOutput("clearedTop", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
